// File: rtl/bfm_ahbl2apb_pm.sv
// AHB-Lite slave to APB3 master bridge (PCLK_PM domain): one AHB word transfer becomes one APB access.
// Optional ACCESS watchdog enabled by defining BFM_AHBL2APB_TIMEOUT_EN.
module bfm_ahbl2apb_pm #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        PCLK_PM,
  input  logic        PRESETN_PM,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        PSEL_PM,
  output logic [31:0] PADDR_PM,
  output logic        PWRITE_PM,
  output logic        PENABLE_PM,
  output logic [31:0] PWDATA_PM,
  input  logic [31:0] PRDATA_PM,
  input  logic        PREADY_PM,
  input  logic        PSLVERR_PM,
  output logic        TIMEOUT_FLG
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  logic [2:0] state;
  logic       accept;
  logic       timeout_hit;
  logic       unused;

  // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  assign accept = HSEL & HTRANS[1] & HREADY;
  assign unused = &{1'b0, HTRANS[0]};

`ifdef BFM_AHBL2APB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_flg;

  assign timeout_hit = (state == ST_ACCESS) && !PREADY_PM && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT_FLG = to_flg;

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      to_cnt <= '0;
      to_flg <= 1'b0;
    end else begin
      if (state == ST_SETUP)
        to_cnt <= '0;
      else if (state == ST_ACCESS && !PREADY_PM)
        to_cnt <= to_cnt + 16'd1;
      if (timeout_hit)
        to_flg <= 1'b1;
    end
  end
`else
  // No watchdog: ACCESS waits for PREADY_PM forever. The expression is constant 0 for any legal
  // TIMEOUT_CYCLES and only keeps the parameter referenced.
  assign timeout_hit = 1'b0;
  assign TIMEOUT_FLG = (TIMEOUT_CYCLES < 1);
`endif

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      state      <= ST_IDLE;
      HREADYOUT  <= 1'b1;
      HRESP      <= 1'b0;
      HRDATA     <= '0;
      PSEL_PM    <= 1'b0;
      PENABLE_PM <= 1'b0;
      PWRITE_PM  <= 1'b0;
      PADDR_PM   <= '0;
      PWDATA_PM  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          if (accept) begin
            HREADYOUT <= 1'b0;
            if (HSIZE == 3'b010) begin
              PADDR_PM  <= HADDR;
              PWRITE_PM <= HWRITE;
              state     <= ST_DATA;
            end else begin
              HRESP <= 1'b1;
              state <= ST_ERR1;
            end
          end
        end
        ST_DATA: begin
          // HWDATA is only valid in the AHB data phase, one cycle after the address was taken.
          PWDATA_PM <= PWRITE_PM ? HWDATA : '0;
          PSEL_PM   <= 1'b1;
          state     <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE_PM <= 1'b1;
          state      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY_PM || timeout_hit) begin
            PSEL_PM    <= 1'b0;
            PENABLE_PM <= 1'b0;
            PWRITE_PM  <= 1'b0;
            PADDR_PM   <= '0;
            PWDATA_PM  <= '0;
            if (PREADY_PM && !PSLVERR_PM) begin
              if (!PWRITE_PM)
                HRDATA <= PRDATA_PM;
              HREADYOUT <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              HRESP <= 1'b1;
              state <= ST_ERR1;
            end
          end
        end
        ST_ERR1: begin
          HRESP     <= 1'b1;
          HREADYOUT <= 1'b1;
          state     <= ST_ERR2;
        end
        ST_ERR2: begin
          HRESP     <= 1'b0;
          HREADYOUT <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          HRESP     <= 1'b0;
          HREADYOUT <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
